aes_round_engine: RTL and testbench
===================================

# aes_round_engine

Iterative AES-128 encryption datapath for the AES-128 core: accepts a 128-bit plaintext block, then runs the initial AddRoundKey and all NUM_ROUNDS rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey; no MixColumns in the final round) on an internal 4x4 byte state. Round keys come from the external key-schedule store, addressed by the engine. The S-box throughput is set by LANES, which trades area against latency. The engine sits between the input block register and the output ciphertext register.

## Interface
- DATA_WIDTH, 128: block width; only 128 is supported.
- NUM_ROUNDS, 10: number of full rounds; the last one omits MixColumns.
- LANES, 16: S-box lookups per cycle; legal values are 1, 2, 4, 8 and 16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_in  in  1  request to load a block; accepted only when ready_out=1.
- state_in  in  128  plaintext block; sampled on the accept cycle.
- key_in  in  128  round key for round_idx_out; valid combinationally in the same cycle.
- ack_in  in  1  consumer acknowledge of the result.
- ready_out  out  1  high only in IDLE.
- round_idx_out  out  4  index of the round key being requested.
- data_out  out  128  ciphertext; valid while done_out=1.
- done_out  out  1  result valid; held high until ack_in.

## Operation
- Byte k (k=0..15) is state_in[127-8k -: 8]. It maps to state row k%4, column k/4 (FIPS-197 column-major). data_out uses the same mapping.
- The FSM has four states: IDLE, LOAD, EXECUTE, DONE.
- **IDLE:** ready_out=1. On start_in=1, state_in is latched and the FSM goes to LOAD with round_idx_out=0.
- **LOAD (1 cycle):** state <= latched block XOR key_in (round key 0). Then round=1, sub_cnt=0, go to EXECUTE.
- **EXECUTE, SubBytes phase:** 16/LANES cycles. In each cycle, bytes sub_cnt*LANES .. sub_cnt*LANES+LANES-1 are replaced in place by their S-box outputs, using LANES instances of the team's aes_sbox. sub_cnt counts 0 .. 16/LANES-1.
- **EXECUTE, mix cycle (1 cycle):** state <= AddRoundKey(MixColumns(ShiftRows(state)), key_in), with round_idx_out=round. MixColumns is bypassed when round==NUM_ROUNDS.
- MixColumns uses xtime reduction with polynomial 0x11B. ShiftRows rotates row r left by r.
- After the mix cycle: if round<NUM_ROUNDS, round increments and the SubBytes phase restarts; otherwise data_out <= new state, done_out=1, go to DONE.
- **DONE:** data_out and done_out are held. On ack_in=1, go to IDLE. A start_in in the same cycle as ack_in is ignored (ready_out is still 0).
- start_in while ready_out=0 is ignored. ack_in outside DONE is ignored.
- round_idx_out is 0 in IDLE and LOAD, equals round in EXECUTE, and is NUM_ROUNDS in DONE.
- Reset asserted mid-operation aborts immediately: state, counters and outputs are forced to reset values, and no partial result is ever presented.

## Timing
- Reset values: ready_out=1, done_out=0, data_out=0, round_idx_out=0, FSM=IDLE, internal state=0.
- Accept edge is cycle 0. LOAD executes in cycle 1.
- done_out rises after L = 1 + NUM_ROUNDS*(16/LANES+1) cycles following the accept edge:
  - LANES=16: L=21.
  - LANES=4: L=51.
  - LANES=1: L=171.
- key_in is used only in LOAD and mix cycles. The bench must drive the key for the round_idx_out value of that same cycle.
- Back-to-back blocks: ack_in at cycle N gives ready_out=1 at cycle N+1, so the earliest next accept is at cycle N+1.
- done_out is high for at least 1 cycle and falls on the edge where ack_in=1 is sampled.

## Test plan
- FIPS-197 C.1: state_in=00112233445566778899aabbccddeeff, key schedule from 000102030405060708090a0b0c0d0e0f, LANES=16 -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a; done_out rises 21 cycles after accept.
- FIPS-197 App. B: state_in=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, LANES=4 -> 3925841d02dc09fbdc118597196a0b32 at cycle 51; round_idx_out sequence is 0,1..10.
- start_in pulsed during EXECUTE, and again together with ack_in in DONE -> both ignored; result unchanged; the next block is accepted only once ready_out=1.
- done_out held for 5 cycles with ack_in=0 -> data_out stable; after ack_in, ready_out=1 the next cycle; a second block (C.1) encrypts correctly back-to-back.
- rst_n pulled low in round 5 -> all outputs at reset values asynchronously; after release, C.1 runs and gives the correct ciphertext.
- LANES=1, C.1 vector -> same ciphertext with done_out at cycle 171.

Source files
------------

// File: rtl/aes_round_engine_if.sv
// Handshake and data bus between the block/key source and the AES round engine.
interface aes_round_engine_if;
  logic         start_in;
  logic [127:0] state_in;
  logic [127:0] key_in;
  logic         ack_in;
  logic         ready_out;
  logic [3:0]   round_idx_out;
  logic [127:0] data_out;
  logic         done_out;

  modport slave (
    input  start_in, state_in, key_in, ack_in,
    output ready_out, round_idx_out, data_out, done_out
  );

  modport master (
    output start_in, state_in, key_in, ack_in,
    input  ready_out, round_idx_out, data_out, done_out
  );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine. The S-box is computed as the GF(2^8)
// multiplicative inverse followed by the affine map, so no 256-entry table is
// needed. LANES S-box instances process the SubBytes phase over 16/LANES cycles.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] sb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sb_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = sb_xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (zero maps to zero), then the FIPS-197 affine transform.
  function automatic logic [7:0] sb_calc(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] r;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 8; i++) begin
      r = (i != 0) ? sb_gf_mul(r, t) : r;
      t = sb_gf_mul(t, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign dout = sb_calc(din);
endmodule

module aes_round_engine #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_ROUNDS = 10,
  parameter int LANES      = 16
) (
  input logic           clk,
  input logic           rst_n,
  aes_round_engine_if.slave bus
);
  localparam int         SUB_STEPS  = 16 / LANES;
  localparam logic [3:0] SUB_LAST   = 4'(SUB_STEPS - 1);
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EXECUTE = 2'd2, DONE = 2'd3} fsm_e;

  fsm_e                  state_r, state_nx;
  logic [DATA_WIDTH-1:0] blk_r;
  logic [DATA_WIDTH-1:0] st_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] mix_s;
  logic [3:0]            round_r;
  logic [3:0]            sub_cnt_r;
  logic                  mix_ph_r;
  logic                  ready_r;
  logic                  done_r;
  logic                  final_s;
  logic [3:0]            lane_idx_s [LANES];
  logic [7:0]            sb_out_s   [LANES];

  function automatic logic [7:0] mc_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // ShiftRows, optional MixColumns, AddRoundKey. Byte k sits at row k%4, col k/4.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic last);
    logic [7:0]   sr [16];
    logic [7:0]   o  [16];
    logic [127:0] res;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      if (last) begin
        for (int r = 0; r < 4; r++) o[4*c+r] = sr[4*c+r];
      end else begin
        o[4*c+0] = mc_xtime(sr[4*c]) ^ mc_xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        o[4*c+1] = sr[4*c] ^ mc_xtime(sr[4*c+1]) ^ mc_xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        o[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ mc_xtime(sr[4*c+2]) ^ mc_xtime(sr[4*c+3]) ^ sr[4*c+3];
        o[4*c+3] = mc_xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ mc_xtime(sr[4*c+3]);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = o[i];
    return res ^ k;
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] sb_in_s;
    assign lane_idx_s[l] = 4'(int'(sub_cnt_r) * LANES + l);
    assign sb_in_s       = st_r[127-8*int'(lane_idx_s[l]) -: 8];
    aes_sbox u_sbox (.din(sb_in_s), .dout(sb_out_s[l]));
  end

  assign final_s = (round_r == LAST_ROUND);
  assign mix_s   = round_fn(st_r, bus.key_in, final_s);

  assign bus.ready_out     = ready_r;
  assign bus.done_out      = done_r;
  assign bus.data_out      = data_r;
  assign bus.round_idx_out = round_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // FSM next-state decode.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (bus.start_in) state_nx = LOAD; else state_nx = IDLE;
      LOAD:    state_nx = EXECUTE;
      EXECUTE: if (mix_ph_r && final_s) state_nx = DONE; else state_nx = EXECUTE;
      DONE:    if (bus.ack_in) state_nx = IDLE; else state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: block latch, round state, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_r     <= '0;
      st_r      <= '0;
      data_r    <= '0;
      round_r   <= 4'd0;
      sub_cnt_r <= 4'd0;
      mix_ph_r  <= 1'b0;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start_in) begin
            blk_r   <= bus.state_in;
            ready_r <= 1'b0;
          end
        end
        LOAD: begin
          st_r      <= blk_r ^ bus.key_in;
          round_r   <= 4'd1;
          sub_cnt_r <= 4'd0;
          mix_ph_r  <= 1'b0;
        end
        EXECUTE: begin
          if (!mix_ph_r) begin
            for (int l = 0; l < LANES; l++) begin
              st_r[127-8*int'(lane_idx_s[l]) -: 8] <= sb_out_s[l];
            end
            if (sub_cnt_r == SUB_LAST) begin
              sub_cnt_r <= 4'd0;
              mix_ph_r  <= 1'b1;
            end else begin
              sub_cnt_r <= sub_cnt_r + 4'd1;
            end
          end else begin
            st_r     <= mix_s;
            mix_ph_r <= 1'b0;
            if (final_s) begin
              data_r <= mix_s;
              done_r <= 1'b1;
            end else begin
              round_r <= round_r + 4'd1;
            end
          end
        end
        DONE: begin
          if (bus.ack_in) begin
            done_r  <= 1'b0;
            ready_r <= 1'b1;
            round_r <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine with LANES = 16, 4 and 1 instances.
module tb_aes_round_engine;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_s [3];
  logic [127:0] pt_s    [3];
  logic         ack_s   [3];
  int           ksel_s  [3];
  logic         ready_w [3];
  logic         done_w  [3];
  logic [3:0]   idx_w   [3];
  logic [127:0] dout_w  [3];
  logic [127:0] rk [2][16];
  int           n_cmp = 0;
  int           n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_engine_if bus_if ();
    assign bus_if.start_in = start_s[g];
    assign bus_if.state_in = pt_s[g];
    assign bus_if.ack_in   = ack_s[g];
    assign bus_if.key_in   = rk[ksel_s[g]][bus_if.round_idx_out];
    assign ready_w[g]      = bus_if.ready_out;
    assign done_w[g]       = bus_if.done_out;
    assign idx_w[g]        = bus_if.round_idx_out;
    assign dout_w[g]       = bus_if.data_out;
    aes_round_engine #(.DATA_WIDTH(128), .NUM_ROUNDS(10),
                       .LANES((g == 0) ? 16 : (g == 1) ? 4 : 1)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference GF(2^8) arithmetic for key expansion (brute-force inverse).
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    logic [7:0] c = 8'h63;
    for (int b = 1; b < 256; b++) begin
      if (a != 8'h00 && tb_mul(a, 8'(b)) == 8'h01) inv = 8'(b);
    end
    for (int i = 0; i < 8; i++) begin
      s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
    end
    return s;
  endfunction

  task automatic expand(input logic [127:0] key, input int sel);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {tb_sbox(t[31:24]) ^ rc, tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[sel][r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Accept one block, optionally pulse start mid-run, measure latency and result.
  task automatic run_block(input int u, input logic [127:0] pt, input int ks,
                           input logic [127:0] exp_ct, input int exp_lat,
                           input int pulse_at, input string tag);
    int n = 0;
    int w = 0;
    logic [3:0] last;
    logic seq_ok;
    ksel_s[u] = ks;
    @(negedge clk);
    while (ready_w[u] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, "_ready"}, ready_w[u], 128'd1);
    start_s[u] = 1'b1;
    pt_s[u] = pt;
    @(posedge clk);
    #1;
    start_s[u] = 1'b0;
    pt_s[u] = ~pt;
    check_eq({tag, "_busy"}, ready_w[u], 128'd0);
    last = idx_w[u];
    seq_ok = (last == 4'd0);
    while (n < 400) begin
      @(posedge clk);
      n++;
      #1;
      start_s[u] = (n == pulse_at);
      if (idx_w[u] != last) begin
        if (idx_w[u] != last + 4'd1) seq_ok = 1'b0;
        last = idx_w[u];
      end
      if (done_w[u] === 1'b1) break;
    end
    start_s[u] = 1'b0;
    check_eq({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check_eq({tag, "_data"}, dout_w[u], exp_ct);
    check_eq({tag, "_idxseq"}, {seq_ok, last}, {1'b1, 4'd10});
  endtask

  // Acknowledge the result, optionally with a simultaneous (ignored) start.
  task automatic ack_block(input int u, input logic with_start, input string tag);
    @(negedge clk);
    ack_s[u] = 1'b1;
    start_s[u] = with_start;
    @(posedge clk);
    #1;
    ack_s[u] = 1'b0;
    start_s[u] = 1'b0;
    check_eq({tag, "_ready"}, ready_w[u], 128'd1);
    check_eq({tag, "_done"}, done_w[u], 128'd0);
    check_eq({tag, "_idx"}, idx_w[u], 128'd0);
  endtask

  initial begin
    int w;
    for (int u = 0; u < 3; u++) begin
      start_s[u] = 1'b0;
      pt_s[u] = 128'h0;
      ack_s[u] = 1'b0;
      ksel_s[u] = 0;
    end
    expand(C1_KEY, 0);
    expand(B_KEY, 1);
    check_eq("ks_c1_r10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check_eq("ks_b_r10", rk[1][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check_eq("rst_ready", ready_w[u], 128'd1);
      check_eq("rst_done", done_w[u], 128'd0);
      check_eq("rst_data", dout_w[u], 128'd0);
      check_eq("rst_idx", idx_w[u], 128'd0);
    end
    rst_n = 1'b1;

    run_block(0, C1_PT, 0, C1_CT, 21, 5, "c1_l16");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("hold_done", done_w[0], 128'd1);
      check_eq("hold_data", dout_w[0], C1_CT);
      check_eq("hold_idx", idx_w[0], 128'd10);
    end
    ack_block(0, 1'b1, "ack_start");
    run_block(0, C1_PT, 0, C1_CT, 21, 0, "b2b");
    ack_block(0, 1'b0, "ack_b2b");

    run_block(1, B_PT, 1, B_CT, 51, 20, "appb_l4");
    ack_block(1, 1'b0, "ack_l4");

    run_block(2, C1_PT, 0, C1_CT, 171, 0, "c1_l1");
    ack_block(2, 1'b0, "ack_l1");

    // Abort in round 5, then re-run the same vector.
    @(negedge clk);
    ksel_s[0] = 0;
    start_s[0] = 1'b1;
    pt_s[0] = C1_PT;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    w = 0;
    while (idx_w[0] != 4'd5 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    check_eq("rst_reach_r5", idx_w[0], 128'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_ready", ready_w[0], 128'd1);
    check_eq("arst_done", done_w[0], 128'd0);
    check_eq("arst_data", dout_w[0], 128'd0);
    check_eq("arst_idx", idx_w[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, C1_PT, 0, C1_CT, 21, 0, "post_rst");
    ack_block(0, 1'b0, "ack_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
